display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl.sv | 114 +++++++++++
 tb/tb_display_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Refresh prescaler, digit scan index and double-buffered display register bank.
// Loads land in a shadow bank and reach the active bank only at a frame boundary.
module display_scan_ctrl #(
    parameter int DIV_WIDTH = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] hex_in,
    input  logic [3:0]  point_in,
    input  logic [3:0]  le_in,
    input  logic        lzb_en,
    output logic [1:0]  scan,
    output logic [15:0] hexin_q,
    output logic [3:0]  pointin_q,
    output logic [3:0]  lein_q,
    output logic        pending,
    output logic        frame_tick
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]           scan_q, scan_d;
    logic [15:0]          hexin_d;
    logic [3:0]           pointin_d, lein_d;
    logic [15:0]          sh_hex_q, sh_hex_d;
    logic [3:0]           sh_point_q, sh_point_d;
    logic [3:0]           sh_le_q, sh_le_d;
    logic                 sh_lzb_q, sh_lzb_d;
    logic                 pending_q, pending_d;
    logic                 frame_tick_q, frame_tick_d;

    logic                 step;
    logic                 boundary;
    logic                 zero3, zero2, zero1;
    logic [3:0]           lzm;

    assign step     = &div_cnt_q;
    assign boundary = step && (scan_q == 2'd3);

    // Blanking runs from the top digit down and stops at the first non-zero nibble.
    assign zero3 = sh_lzb_q && (sh_hex_q[15:12] == 4'h0);
    assign zero2 = zero3 && (sh_hex_q[11:8] == 4'h0);
    assign zero1 = zero2 && (sh_hex_q[7:4] == 4'h0);
    assign lzm   = {zero3, zero2, zero1, 1'b0};

    always_comb begin
        div_cnt_d    = div_cnt_q + DIV_ONE;
        scan_d       = scan_q;
        frame_tick_d = boundary;
        hexin_d      = hexin_q;
        pointin_d    = pointin_q;
        lein_d       = lein_q;
        sh_hex_d     = sh_hex_q;
        sh_point_d   = sh_point_q;
        sh_le_d      = sh_le_q;
        sh_lzb_d     = sh_lzb_q;
        pending_d    = pending_q;

        if (step) begin
            scan_d = scan_q + 2'd1;
        end

        if (boundary && pending_q) begin
            hexin_d   = sh_hex_q;
            pointin_d = sh_point_q;
            lein_d    = sh_le_q | lzm;
            pending_d = 1'b0;
        end

        // A load on the boundary cycle wins over the clear so the new data stays pending.
        if (load) begin
            sh_hex_d   = hex_in;
            sh_point_d = point_in;
            sh_le_d    = le_in;
            sh_lzb_d   = lzb_en;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            scan_q       <= '0;
            frame_tick_q <= 1'b0;
            hexin_q      <= '0;
            pointin_q    <= '0;
            lein_q       <= '0;
            sh_hex_q     <= '0;
            sh_point_q   <= '0;
            sh_le_q      <= '0;
            sh_lzb_q     <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            scan_q       <= scan_d;
            frame_tick_q <= frame_tick_d;
            hexin_q      <= hexin_d;
            pointin_q    <= pointin_d;
            lein_q       <= lein_d;
            sh_hex_q     <= sh_hex_d;
            sh_point_q   <= sh_point_d;
            sh_le_q      <= sh_le_d;
            sh_lzb_q     <= sh_lzb_d;
            pending_q    <= pending_d;
        end
    end

    assign scan       = scan_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a small prescaler; a cycle-count
// based reference model predicts every output after each rising edge.
module tb_display_scan_ctrl;

    localparam int DW = 2;
    localparam int STEP_CLKS  = 1 << DW;
    localparam int FRAME_CLKS = 4 * STEP_CLKS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  point_in = '0;
    logic [3:0]  le_in = '0;
    logic        lzb_en = 1'b0;
    logic [1:0]  scan;
    logic [15:0] hexin_q;
    logic [3:0]  pointin_q;
    logic [3:0]  lein_q;
    logic        pending;
    logic        frame_tick;

    display_scan_ctrl #(.DIV_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .load(load), .hex_in(hex_in), .point_in(point_in),
        .le_in(le_in), .lzb_en(lzb_en), .scan(scan), .hexin_q(hexin_q),
        .pointin_q(pointin_q), .lein_q(lein_q), .pending(pending), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: k counts edges since reset released.
    int          k = 0;
    int          m_scan = 0;
    bit          m_tick = 0;
    bit          m_pend = 0;
    logic [15:0] m_hex = '0, s_hex = '0;
    logic [3:0]  m_point = '0, s_point = '0;
    logic [3:0]  m_le = '0, s_le = '0;
    bit          s_lzb = 0;
    bit          seen_aaaa = 0;

    function automatic logic [3:0] lz_mask(input logic [15:0] v, input bit en);
        int lz = 0;
        logic [3:0] m = '0;
        if (en) begin
            while (lz < 3 && v[15 - 4*lz -: 4] == 4'h0) lz++;
            for (int d = 0; d < lz; d++) m[3-d] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [27:0] exp_vec();
        logic [1:0] s = m_scan[1:0];
        return {s, m_hex, m_point, m_le, m_pend, m_tick};
    endfunction

    wire [27:0] dut_vec = {scan, hexin_q, pointin_q, lein_q, pending, frame_tick};

    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            k = 0; m_scan = 0; m_tick = 0; m_pend = 0;
            m_hex = '0; m_point = '0; m_le = '0;
            s_hex = '0; s_point = '0; s_le = '0; s_lzb = 0;
        end else begin
            k++;
            m_scan = (k / STEP_CLKS) % 4;
            m_tick = (k % FRAME_CLKS) == 0;
            if (m_tick && m_pend) begin
                m_hex = s_hex; m_point = s_point;
                m_le = s_le | lz_mask(s_hex, s_lzb);
                m_pend = 0;
            end
            if (load) begin
                s_hex = hex_in; s_point = point_in; s_le = le_in; s_lzb = lzb_en;
                m_pend = 1;
            end
        end
        #1;
        if (hexin_q == 16'hAAAA) seen_aaaa = 1;
    endtask

    task automatic drive_load(input logic [15:0] h, input logic [3:0] p,
                              input logic [3:0] l, input logic z);
        load = 1'b1; hex_in = h; point_in = p; le_in = l; lzb_en = z;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_checks++;
            if (dut_vec !== 28'h0) begin
                n_fail++;
                $display("FAIL reset_state got=%h exp=%h", dut_vec, 28'h0);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_scan k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_basic_load();
        for (int i = 0; i < FRAME_CLKS && !(m_scan == 1); i++) cyc();
        drive_load(16'h1234, 4'b0100, 4'b0000, 1'b0);
        cyc();
        load = 1'b0;
        n_checks++;
        if (pending !== 1'b1 || hexin_q !== 16'h0) begin
            n_fail++;
            $display("FAIL load_pending got=%b/%h exp=1/0000", pending, hexin_q);
        end
        for (int i = 0; i < FRAME_CLKS + 2; i++) begin
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL basic_load k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if ({hexin_q, pointin_q, lein_q, pending} !== {16'h1234, 4'b0100, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_commit got=%h/%b/%b/%b exp=1234/0100/0000/0",
                     hexin_q, pointin_q, lein_q, pending);
        end
    endtask

    task automatic test_lzb();
        logic [15:0] hv [3] = '{16'h0050, 16'h0000, 16'h0050};
        logic [3:0]  lv [3] = '{4'b0000, 4'b0000, 4'b0001};
        logic [3:0]  ev [3] = '{4'b1100, 4'b1110, 4'b1101};
        for (int t = 0; t < 3; t++) begin
            drive_load(hv[t], 4'b0000, lv[t], 1'b1);
            cyc();
            load = 1'b0;
            for (int i = 0; i < FRAME_CLKS; i++) begin
                cyc();
                n_checks++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL lzb_track t=%0d got=%h exp=%h", t, dut_vec, exp_vec());
                end
            end
            n_checks++;
            if (lein_q !== ev[t]) begin
                n_fail++;
                $display("FAIL lzb_mask t=%0d got=%b exp=%b", t, lein_q, ev[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < FRAME_CLKS && (k % FRAME_CLKS) != 1; i++) cyc();
        seen_aaaa = 0;
        drive_load(16'hAAAA, 4'h0, 4'h0, 1'b0);
        cyc();
        load = 1'b0;
        cyc(); cyc();
        drive_load(16'hBBBB, 4'h0, 4'h0, 1'b0);
        cyc();
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (hexin_q !== 16'hBBBB || seen_aaaa) begin
            n_fail++;
            $display("FAIL last_write_wins got=%h saw_aaaa=%0d exp=bbbb saw_aaaa=0", hexin_q, seen_aaaa);
        end
    endtask

    task automatic test_boundary_load();
        for (int i = 0; i < FRAME_CLKS && ((k + 1) % FRAME_CLKS) != 5; i++) cyc();
        drive_load(16'h1111, 4'h0, 4'h0, 1'b0);
        cyc();
        load = 1'b0;
        for (int i = 0; i < FRAME_CLKS && ((k + 1) % FRAME_CLKS) != 0; i++) cyc();
        drive_load(16'hCCCC, 4'h0, 4'h0, 1'b0);
        cyc();
        load = 1'b0;
        n_checks++;
        if ({hexin_q, pending, frame_tick} !== {16'h1111, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL boundary_load got=%h/%b/%b exp=1111/1/1", hexin_q, pending, frame_tick);
        end
        for (int i = 0; i < FRAME_CLKS; i++) begin
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL boundary_next k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (hexin_q !== 16'hCCCC || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_second got=%h/%b exp=cccc/0", hexin_q, pending);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < FRAME_CLKS && (k % FRAME_CLKS) != 8; i++) cyc();
        drive_load(16'h9876, 4'hF, 4'h0, 1'b0);
        cyc();
        load = 1'b0;
        n_checks++;
        if (pending !== 1'b1 || scan !== 2'd2) begin
            n_fail++;
            $display("FAIL pre_reset got=%b/%0d exp=1/2", pending, scan);
        end
        rst = 1'b1;
        drive_load(16'h5555, 4'hF, 4'hF, 1'b1);
        cyc();
        rst = 1'b0;
        load = 1'b0;
        n_checks++;
        if (dut_vec !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_mid got=%h exp=%h", dut_vec, 28'h0);
        end
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec() || hexin_q === 16'h9876) begin
                n_fail++;
                $display("FAIL after_reset k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0)
                drive_load(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            else
                load = 1'b0;
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_lzb();
        test_back_to_back();
        test_boundary_load();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
